nes_pad_reader: RTL and testbench

- Host-side initiator for physical NES gamepads (CD4021 shift-register pads). The CPU-side controller responder serves $4016/$4017 to the 6502; this block is its hardware counterpart.
- Periodically pulses latch, clocks out 8 serial bits from up to two pads sharing latch/clock, and de-inverts the active-low data.
- Presents stable parallel button bytes to the controller wrapper in the clk_CPU domain.

---
 rtl/nes_pad_reader.sv | 167 ++++++++++++++++
 tb/tb_nes_pad_reader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_pad_reader.sv
// Host-side poller for up to two CD4021-based NES pads sharing latch/clock.
// Latches, clocks out 8 serial bits per pad and commits both bytes atomically.
module nes_pad_reader #(
  parameter int LATCH_CYCLES = 12,
  parameter int HALF_CYCLES  = 6,
  parameter int POLL_CYCLES  = 29830
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons0,
  output logic [7:0] buttons1,
  output logic       valid
);

  localparam int PH_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int POLL_W = $clog2(POLL_CYCLES + 1);

  localparam logic [PH_W-1:0]   LATCH_LAST = PH_W'(LATCH_CYCLES - 1);
  localparam logic [PH_W-1:0]   HALF_LAST  = PH_W'(HALF_CYCLES - 1);
  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_GAP, S_CLK_HI, S_CLK_LO, S_DONE, S_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [2:0]        bit_q, bit_d;
  logic [POLL_W-1:0] poll_q, poll_d;
  logic              latch_q, latch_d;
  logic              pclk_q, pclk_d;
  logic              valid_q, valid_d;
  logic [1:0][7:0]   sh_q, sh_d;
  logic [1:0][7:0]   btn_q, btn_d;
  logic [1:0]        sync1_q, sync1_d;
  logic [1:0]        sync2_q, sync2_d;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    poll_d  = (poll_q >= POLL_LAST) ? poll_q : poll_q + 1'b1;
    latch_d = 1'b0;
    pclk_d  = 1'b0;
    valid_d = 1'b0;
    sh_d    = sh_q;
    btn_d   = btn_q;
    sync1_d = pad_data;
    sync2_d = sync1_q;

    case (state_q)
      S_IDLE: begin
        poll_d = poll_q;
        if (enable) begin
          state_d = S_LATCH;
          phase_d = '0;
          poll_d  = '0;
          latch_d = 1'b1;
        end
      end
      S_LATCH: begin
        if (phase_q == LATCH_LAST) begin
          state_d = S_GAP;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
          latch_d = 1'b1;
        end
      end
      S_GAP: begin
        if (phase_q == HALF_LAST) begin
          // Pads present A on their output right after the latch falls.
          for (int p = 0; p < 2; p++) sh_d[p][0] = ~sync2_q[p];
          state_d = S_CLK_HI;
          phase_d = '0;
          bit_d   = 3'd1;
          pclk_d  = 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_CLK_HI: begin
        if (phase_q == HALF_LAST) begin
          state_d = S_CLK_LO;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
          pclk_d  = 1'b1;
        end
      end
      S_CLK_LO: begin
        if (phase_q == HALF_LAST) begin
          for (int p = 0; p < 2; p++) sh_d[p][bit_q] = ~sync2_q[p];
          phase_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CLK_HI;
            bit_d   = bit_q + 3'd1;
            pclk_d  = 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_DONE: begin
        btn_d   = sh_q;
        valid_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Poll counter started at latch rise, so a short period exits immediately.
        if (poll_q >= POLL_LAST) begin
          if (enable) begin
            state_d = S_LATCH;
            phase_d = '0;
            poll_d  = '0;
            latch_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      poll_q  <= '0;
      latch_q <= 1'b0;
      pclk_q  <= 1'b0;
      valid_q <= 1'b0;
      sh_q    <= '0;
      btn_q   <= '0;
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      poll_q  <= poll_d;
      latch_q <= latch_d;
      pclk_q  <= pclk_d;
      valid_q <= valid_d;
      sh_q    <= sh_d;
      btn_q   <= btn_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign pad_latch = latch_q;
  assign pad_clk   = pclk_q;
  assign buttons0  = btn_q[0];
  assign buttons1  = btn_q[1];
  assign valid     = valid_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Scoreboard bench for nes_pad_reader: a CD4021 pad model feeds serial data,
// expected bytes are queued at each latch rise and checked when valid pulses.
module tb_nes_pad_reader;

  localparam int POLL = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] pad_data;
  logic       pad_latch, pad_clk, valid;
  logic [7:0] buttons0, buttons1;

  always #5 clk = ~clk;

  nes_pad_reader #(
    .LATCH_CYCLES(12),
    .HALF_CYCLES (6),
    .POLL_CYCLES (POLL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .pad_data (pad_data),
    .pad_latch(pad_latch),
    .pad_clk  (pad_clk),
    .buttons0 (buttons0),
    .buttons1 (buttons1),
    .valid    (valid)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Directed vector: serial line patterns and hand-computed expected bytes
  logic [7:0] l0 = 8'hFF, l1 = 8'hFF, e0 = 8'h00, e1 = 8'h00;
  logic       hold_en = 1'b0;
  logic [1:0] hold_val = 2'b11;
  logic [7:0] sr0 = 8'hFF, sr1 = 8'hFF;

  typedef struct packed {
    logic [7:0] b0;
    logic [7:0] b1;
  } exp_t;
  exp_t exp_q[$];

  // Pad model: parallel load on latch, shift on clk rise (pull-up shifted in)
  always @(posedge pad_latch or posedge pad_clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (pad_latch) begin
      sr0 = l0;
      sr1 = l1;
      exp_q.push_back({e0, e1});
    end else begin
      sr0 = {1'b1, sr0[7:1]};
      sr1 = {1'b1, sr1[7:1]};
    end
  end

  assign pad_data = hold_en ? hold_val : {sr1[0], sr0[0]};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   epoch = 0;
  int   last_rise = -1, rise_epoch = -1, latch_run = 0;
  int   clk_rises = 0, last_clk_rise = 0, high_run = 0;
  int   n_latch = 0, n_valid = 0;
  logic prev_latch = 1'b0, prev_pclk = 1'b0;
  logic [7:0] last_b0 = 8'h00, last_b1 = 8'h00;
  int   changed = 0;
  exp_t ex;

  // Monitor: timing checks and scoreboard pop, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      last_b0 = 8'h00;
      last_b1 = 8'h00;
      changed = 0;
    end else begin
      if (pad_latch && !prev_latch) begin
        if (last_rise >= 0 && rise_epoch == epoch) chk("latch_period", cyc - last_rise, POLL);
        last_rise  = cyc;
        rise_epoch = epoch;
        latch_run  = 0;
        clk_rises  = 0;
        n_latch++;
      end
      if (pad_latch) latch_run++;
      if (!pad_latch && prev_latch) chk("latch_width", latch_run, 12);

      if (pad_clk && !prev_pclk) begin
        clk_rises++;
        if (clk_rises == 1) chk("first_clk_offset", cyc - last_rise, 18);
        else chk("clk_period", cyc - last_clk_rise, 12);
        last_clk_rise = cyc;
        high_run = 0;
      end
      if (pad_clk) high_run++;
      if (!pad_clk && prev_pclk) chk("clk_high_width", high_run, 6);

      if (valid) begin
        n_valid++;
        chk("valid_offset", cyc - last_rise, 103);
        chk("clk_rises_per_frame", clk_rises, 7);
        chk("buttons_stable", changed, 0);
        chk("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          ex = exp_q.pop_front();
          chk("buttons0", int'(buttons0), int'(ex.b0));
          chk("buttons1", int'(buttons1), int'(ex.b1));
        end
        $display("valid @%0d: buttons0=%02h buttons1=%02h", cyc, buttons0, buttons1);
        last_b0 = buttons0;
        last_b1 = buttons1;
        changed = 0;
      end else if (buttons0 != last_b0 || buttons1 != last_b1) begin
        changed = 1;
      end
    end
    prev_latch = pad_latch;
    prev_pclk  = pad_clk;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int k;
    for (k = 0; k < 400; k++) begin
      step(1);
      if (valid) break;
    end
    chk(name, int'(k < 400), 1);
  endtask

  task automatic wait_latch_rise(input string name);
    int k;
    int n0;
    n0 = n_latch;
    for (k = 0; k < 400; k++) begin
      step(1);
      if (n_latch != n0) break;
    end
    chk(name, int'(k < 400), 1);
  endtask

  task automatic wait_rises(input string name, input int n);
    int k;
    for (k = 0; k < 400; k++) begin
      step(1);
      if (clk_rises == n) break;
    end
    chk(name, int'(k < 400), 1);
  endtask

  task automatic set_vec(input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] x0, input logic [7:0] x1);
    l0 = a0;
    l1 = a1;
    e0 = x0;
    e1 = x1;
  endtask

  int nl_snap, nv_snap;

  initial begin
    #2 rst_n = 1'b0;
    step(3);
    chk("rst_pad_latch", pad_latch, 0);
    chk("rst_pad_clk", pad_clk, 0);
    chk("rst_buttons0", buttons0, 0);
    chk("rst_buttons1", buttons1, 0);
    chk("rst_valid", valid, 0);
    rst_n = 1'b1;
    step(3);
    chk("idle_no_latch", pad_latch, 0);

    // Test 1: A pressed on pad 0
    set_vec(8'hFE, 8'hFF, 8'h01, 8'h00);
    enable = 1'b1;
    step(1);
    chk("latch_after_idle", pad_latch, 1);
    wait_valid("t1_valid_timeout");

    // Test 2: Start+Right on pad 0, B+Up on pad 1
    set_vec(8'h77, 8'hED, 8'h88, 8'h12);
    wait_valid("t2_valid_timeout");

    // Test 3: steady polling, pattern changes mid-frame
    set_vec(8'hF0, 8'h0F, 8'h0F, 8'hF0);
    wait_latch_rise("t3_latch_timeout");
    step(40);
    set_vec(8'h3C, 8'hC3, 8'hC3, 8'h3C);
    wait_valid("t3a_valid_timeout");
    wait_valid("t3b_valid_timeout");

    // Test 4: drop enable during CLK_HI of bit 3
    set_vec(8'hAA, 8'h55, 8'h55, 8'hAA);
    wait_latch_rise("t4_latch_timeout");
    wait_rises("t4_rise_timeout", 3);
    step(2);
    enable = 1'b0;
    epoch++;
    wait_valid("t4_valid_timeout");
    step(3);
    chk("t4_latch_low", pad_latch, 0);
    chk("t4_clk_low", pad_clk, 0);
    nl_snap = n_latch;
    step(300);
    chk("t4_no_relatch", n_latch, nl_snap);

    // Test 5: reset during CLK_LO of bit 5
    set_vec(8'h00, 8'h00, 8'hFF, 8'hFF);
    enable = 1'b1;
    wait_latch_rise("t5_latch_timeout");
    wait_rises("t5_rise_timeout", 5);
    step(8);
    chk("t5_prior_buttons0", buttons0, 8'h55);
    nv_snap = n_valid;
    #2 rst_n = 1'b0;
    epoch++;
    #1;
    chk("t5_async_pad_clk", pad_clk, 0);
    chk("t5_async_latch", pad_latch, 0);
    chk("t5_async_buttons0", buttons0, 0);
    chk("t5_async_buttons1", buttons1, 0);
    chk("t5_async_valid", valid, 0);
    step(5);
    chk("t5_no_valid", n_valid, nv_snap);
    set_vec(8'h7E, 8'hBD, 8'h81, 8'h42);
    rst_n = 1'b1;
    step(1);
    chk("t5_latch_after_release", pad_latch, 1);
    wait_valid("t5_valid_timeout");

    // Test 6: lines held high (unplugged), then held low
    hold_en  = 1'b1;
    hold_val = 2'b11;
    set_vec(8'hFF, 8'hFF, 8'h00, 8'h00);
    wait_valid("t6a_valid_timeout");
    hold_val = 2'b00;
    set_vec(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    wait_valid("t6b_valid_timeout");

    enable = 1'b0;
    epoch++;
    step(300);
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
